// File: rtl/ram_port_arbiter.sv
// Arbiter that shares the single-port data RAM between the CPU (port C) and the
// read-only frame-fetch engine (port D). The CPU has fixed priority. A starvation
// counter forces a D grant after MAX_WAIT denied cycles. A lock lets D own the RAM
// for bursts of up to BURST_MAX grants. The RAM read data is sampled on the grant
// edge and returned with a one-cycle rvalid pulse to the port that issued the read.
module ram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_wEn,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    // A one-grant burst is the same as a plain D grant, so the burst state is
    // only entered when it can actually hold the RAM for more than one cycle.
    localparam bit BURST_EN = (BURST_MAX > 1);

    typedef enum logic {S_SHARE, S_BURST} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_t;

    state_t            state_q,    state_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic [SW-1:0]     starve_q,   starve_d;
    logic [BW-1:0]     burst_q,    burst_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] c_rdata_q,  c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              gnt_c, gnt_d, wen;

    // Grant decision: at most one port wins per cycle.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (state_q == S_BURST) begin
            gnt_d = d_req;
        end else if (d_req && (starve_q == SW'(MAX_WAIT))) begin
            gnt_d = 1'b1;
        end else if (c_req) begin
            gnt_c = 1'b1;
        end else if (d_req) begin
            gnt_d = 1'b1;
        end
    end

    // RAM port mux. Address and write data hold their last value when idle, and
    // the write enable is driven only by a granted CPU access.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen     = 1'b0;
        if (gnt_c) begin
            addr_d  = c_addr;
            wdata_d = c_wdata;
            wen     = c_wEn;
        end else if (gnt_d) begin
            addr_d  = d_addr;
        end
    end

    // Next-state logic: starvation counter, burst tracking and read return capture.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        starve_d   = '0;
        rd_owner_d = OWN_NONE;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (d_req && !gnt_d) begin
            starve_d = (starve_q == SW'(MAX_WAIT)) ? starve_q : starve_q + SW'(1);
        end

        if (gnt_c && !c_wEn) begin
            rd_owner_d = OWN_C;
            c_rdata_d  = ram_dataOut;
        end else if (gnt_d) begin
            rd_owner_d = OWN_D;
            d_rdata_d  = ram_dataOut;
        end

        case (state_q)
            S_SHARE: begin
                if (gnt_d && d_lock && BURST_EN) begin
                    state_d = S_BURST;
                    burst_d = BW'(1);
                end
            end
            S_BURST: begin
                if (gnt_d) begin
                    burst_d = burst_q + BW'(1);
                end
                // Leaving the burst hands the next cycle to a waiting CPU,
                // because every burst grant also cleared the starvation count.
                if (!d_lock || !d_req || (gnt_d && (burst_q + BW'(1) == BW'(BURST_MAX)))) begin
                    state_d = S_SHARE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_SHARE;
                burst_d = '0;
            end
        endcase
    end

    // State registers; reset drops any in-flight read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_SHARE;
            rd_owner_q <= OWN_NONE;
            starve_q   <= '0;
            burst_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_gnt      = gnt_c;
    assign d_gnt      = gnt_d;
    assign ram_wEn    = wen;
    assign ram_addr   = addr_d;
    assign ram_dataIn = wdata_d;
    assign c_rvalid   = (rd_owner_q == OWN_C);
    assign d_rvalid   = (rd_owner_q == OWN_D);
    assign c_rdata    = c_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM model.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              c_req = 1'b0, c_wEn = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic              c_gnt, c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              d_req = 1'b0, d_lock = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn, ram_dataOut;

    int vectors = 0;
    int errors  = 0;

    // RAM model: a fixed pattern, word 5 = 0xA5, plus the last written word.
    logic              wr_vld = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_dat = '0;

    function automatic logic [31:0] pat(input int a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    assign ram_dataOut = (wr_vld && ram_addr == wr_addr) ? wr_dat :
                         (ram_addr == 12'd5) ? 32'h0000_00A5 : pat(int'(ram_addr));

    always @(posedge clk) begin
        if (ram_wEn) begin
            wr_vld  <= 1'b1;
            wr_addr <= ram_addr;
            wr_dat  <= ram_dataIn;
        end
    end

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_wEn(c_wEn), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL reset_c_rvalid got %0b want 0", c_rvalid); end
        vectors++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid got %0b want 0", d_rvalid); end
        vectors++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL reset_c_rdata got %h want 0", c_rdata); end
        vectors++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
        vectors++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL reset_ram_wEn got %0b want 0", ram_wEn); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got c=%0b d=%0b want 0 0", c_gnt, d_gnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        c_req = 1'b1; c_wEn = 1'b0; c_addr = 12'd5;
        @(negedge clk);
        vectors++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL cpu_read_c_gnt got %0b want 1", c_gnt); end
        vectors++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL cpu_read_d_gnt got %0b want 0", d_gnt); end
        vectors++; if (ram_addr !== 12'd5 || ram_wEn !== 1'b0) begin errors++; $display("FAIL cpu_read_ram got addr=%0d wEn=%0b want 5 0", ram_addr, ram_wEn); end
        @(posedge clk); #1;
        c_req = 1'b0;
        vectors++; if (c_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_read_rvalid got %0b want 1", c_rvalid); end
        vectors++; if (c_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL cpu_read_rdata got %h want 000000a5", c_rdata); end
        vectors++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_d_rvalid got %0b want 0", d_rvalid); end
        @(posedge clk); #1;
        vectors++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_pulse got %0b want 0", c_rvalid); end
        vectors++; if (c_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL cpu_read_hold got %h want 000000a5", c_rdata); end
    endtask

    // C and D both held, no lock: D wins only when starved for MAX_WAIT cycles.
    task automatic test_starvation();
        logic [9:0] exp_d;
        exp_d = 10'b10_0001_0000;
        c_req = 1'b1; c_wEn = 1'b0; c_addr = 12'd10;
        d_req = 1'b1; d_lock = 1'b0; d_addr = 12'd20;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++; if (d_gnt !== exp_d[k] || c_gnt !== !exp_d[k]) begin errors++; $display("FAIL starve_gnt[%0d] got c=%0b d=%0b want c=%0b d=%0b", k, c_gnt, d_gnt, !exp_d[k], exp_d[k]); end
            @(posedge clk); #1;
            vectors++; if (d_rvalid !== exp_d[k] || c_rvalid !== !exp_d[k]) begin errors++; $display("FAIL starve_rvalid[%0d] got c=%0b d=%0b want c=%0b d=%0b", k, c_rvalid, d_rvalid, !exp_d[k], exp_d[k]); end
            if (exp_d[k]) begin
                vectors++; if (d_rdata !== pat(20)) begin errors++; $display("FAIL starve_d_rdata[%0d] got %h want %h", k, d_rdata, pat(20)); end
            end else begin
                vectors++; if (c_rdata !== pat(10)) begin errors++; $display("FAIL starve_c_rdata[%0d] got %h want %h", k, c_rdata, pat(10)); end
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Locked burst forced by starvation: 8 D grants, one C grant, burst resumes.
    task automatic test_burst();
        logic [14:0] exp_d;
        int da;
        exp_d = 15'b110_1111_1111_0000;
        da = 100;
        c_wEn = 1'b0; c_addr = 12'd7;
        d_req = 1'b1; d_lock = 1'b1; d_addr = 12'(da);
        for (int k = 0; k < 15; k++) begin
            c_req = (k <= 12);
            @(negedge clk);
            vectors++; if (d_gnt !== exp_d[k] || c_gnt !== !exp_d[k]) begin errors++; $display("FAIL burst_gnt[%0d] got c=%0b d=%0b want c=%0b d=%0b", k, c_gnt, d_gnt, !exp_d[k], exp_d[k]); end
            if (exp_d[k]) begin
                vectors++; if (ram_addr !== 12'(da) || ram_wEn !== 1'b0) begin errors++; $display("FAIL burst_addr[%0d] got addr=%0d wEn=%0b want %0d 0", k, ram_addr, ram_wEn, da); end
            end
            @(posedge clk); #1;
            vectors++; if (d_rvalid !== exp_d[k] || c_rvalid !== !exp_d[k]) begin errors++; $display("FAIL burst_rvalid[%0d] got c=%0b d=%0b want c=%0b d=%0b", k, c_rvalid, d_rvalid, !exp_d[k], exp_d[k]); end
            if (exp_d[k]) begin
                vectors++; if (d_rdata !== pat(da)) begin errors++; $display("FAIL burst_d_rdata[%0d] got %h want %h", k, d_rdata, pat(da)); end
                da++;
                d_addr = 12'(da);
            end else begin
                vectors++; if (c_rdata !== pat(7)) begin errors++; $display("FAIL burst_c_rdata[%0d] got %h want %h", k, c_rdata, pat(7)); end
            end
        end
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        @(posedge clk); #1;
    endtask

    // CPU write to an MMIO address while D is requesting.
    task automatic test_write_mmio();
        c_req = 1'b1; c_wEn = 1'b1; c_addr = 12'd1001; c_wdata = 32'h1F;
        d_req = 1'b1; d_lock = 1'b0; d_addr = 12'd50;
        @(negedge clk);
        vectors++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got c=%0b d=%0b want 1 0", c_gnt, d_gnt); end
        vectors++; if (ram_wEn !== 1'b1 || ram_addr !== 12'd1001 || ram_dataIn !== 32'h1F) begin errors++; $display("FAIL wr_port got wEn=%0b addr=%0d data=%h want 1 1001 1f", ram_wEn, ram_addr, ram_dataIn); end
        @(posedge clk); #1;
        vectors++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %0b want 0", c_rvalid); end
        c_req = 1'b0; c_wEn = 1'b0;
        @(negedge clk);
        vectors++; if (d_gnt !== 1'b1 || ram_wEn !== 1'b0 || ram_addr !== 12'd50) begin errors++; $display("FAIL wr_d_cycle got gnt=%0b wEn=%0b addr=%0d want 1 0 50", d_gnt, ram_wEn, ram_addr); end
        @(posedge clk); #1;
        d_req = 1'b0;
        vectors++; if (d_rvalid !== 1'b1 || d_rdata !== pat(50)) begin errors++; $display("FAIL wr_d_read got v=%0b data=%h want 1 %h", d_rvalid, d_rdata, pat(50)); end
        c_req = 1'b1; c_addr = 12'd1001;
        @(negedge clk);
        vectors++; if (c_gnt !== 1'b1 || ram_wEn !== 1'b0) begin errors++; $display("FAIL wr_readback_gnt got gnt=%0b wEn=%0b want 1 0", c_gnt, ram_wEn); end
        @(posedge clk); #1;
        c_req = 1'b0;
        vectors++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h1F) begin errors++; $display("FAIL wr_readback got v=%0b data=%h want 1 0000001f", c_rvalid, c_rdata); end
        @(posedge clk); #1;
    endtask

    // Reset during a locked D burst, then arbitration restarts from scratch.
    task automatic test_reset_mid();
        logic [4:0] exp_d;
        exp_d = 5'b10000;
        c_req = 1'b0; d_req = 1'b1; d_lock = 1'b1; d_addr = 12'd30;
        @(negedge clk);
        vectors++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_first_gnt got %0b want 1", d_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0; d_lock = 1'b0;
        #1;
        vectors++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_async got v=%0b data=%h want 0 0", d_rvalid, d_rdata); end
        @(posedge clk); #1;
        vectors++; if (d_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_hold got c=%0b d=%0b want 0 0", c_rvalid, d_rvalid); end
        reset = 1'b0;
        c_req = 1'b1; c_wEn = 1'b0; c_addr = 12'd41;
        d_req = 1'b1; d_lock = 1'b1; d_addr = 12'd40;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (d_gnt !== exp_d[k] || c_gnt !== !exp_d[k]) begin errors++; $display("FAIL rst_mid_gnt[%0d] got c=%0b d=%0b want c=%0b d=%0b", k, c_gnt, d_gnt, !exp_d[k], exp_d[k]); end
            @(posedge clk); #1;
        end
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        @(posedge clk); #1;
    endtask

    // Idle bus: no grants, no writes, address holds; d_lock alone does nothing.
    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            d_lock = (k < 5);
            @(negedge clk);
            vectors++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_wEn !== 1'b0) begin errors++; $display("FAIL idle_port[%0d] got c=%0b d=%0b wEn=%0b want 0 0 0", k, c_gnt, d_gnt, ram_wEn); end
            vectors++; if (ram_addr !== 12'd40) begin errors++; $display("FAIL idle_addr[%0d] got %0d want 40", k, ram_addr); end
            @(posedge clk); #1;
            vectors++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid[%0d] got c=%0b d=%0b want 0 0", k, c_rvalid, d_rvalid); end
        end
        d_lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_starvation();
        test_burst();
        test_write_mmio();
        test_reset_mid();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port processor data RAM between two requesters: the CPU (port C) and a read-only frame-fetch engine (port D) that streams pattern data to the hologram display.
- Sits between both requesters and the RAM/MMIO block.
- Gives the CPU fixed priority, with two limits:
  - a starvation bound guarantees port D progress;
  - a bounded lock lets port D hold the RAM for short bursts.

Parameters:
ADDR_W, 12, RAM word-address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive denied cycles after which port D must win
BURST_MAX, 8, maximum consecutive grants port D may hold under lock

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
c_req  in  1  CPU access request, held until c_gnt
c_wEn  in  1  CPU write enable (qualified by c_req)
c_addr  in  ADDR_W  CPU word address
c_wdata  in  DATA_W  CPU write data
c_gnt  out  1  CPU access accepted this cycle (combinational)
c_rvalid  out  1  CPU read data valid (registered)
c_rdata  out  DATA_W  CPU read data
d_req  in  1  frame-fetch read request, held until d_gnt
d_lock  in  1  frame-fetch requests burst ownership
d_addr  in  ADDR_W  frame-fetch word address
d_gnt  out  1  frame-fetch access accepted this cycle (combinational)
d_rvalid  out  1  frame-fetch read data valid (registered)
d_rdata  out  DATA_W  frame-fetch read data
ram_wEn  out  1  to RAM/MMIO write enable
ram_addr  out  ADDR_W  to RAM/MMIO address
ram_dataIn  out  DATA_W  to RAM/MMIO write data
ram_dataOut  in  DATA_W  from RAM/MMIO read data, valid one cycle after address

Behaviour:
- States: S_SHARE (CPU priority) and S_BURST (port D owns the RAM).
- Reset values:
  - state = S_SHARE; starve_cnt = 0; burst_cnt = 0; rd_owner = none.
  - c_rvalid = d_rvalid = 0.
  - ram_wEn = 0; rdata outputs = 0.
- Grant decision in S_SHARE (combinational, one grant per cycle max):
  - If d_req and starve_cnt == MAX_WAIT, grant D.
  - Else if c_req, grant C.
  - Else if d_req, grant D.
  - Else no grant.
- Grant decision in S_BURST: grant D if d_req; otherwise no grant. c_req waits.
- Muxing:
  - On a C grant: ram_addr = c_addr, ram_dataIn = c_wdata, ram_wEn = c_wEn.
  - On a D grant: ram_addr = d_addr, ram_wEn = 0.
  - With no grant: ram_wEn = 0 and ram_addr holds its last value (no spurious writes).
- Read return:
  - A granted read (C with c_wEn=0, or any D) sets the matching rvalid for exactly one cycle on the next edge, with rdata registered from ram_dataOut at that edge.
  - Writes produce no rvalid.
  - rdata holds its value between valids.
  - Back-to-back grants to either port give back-to-back rvalids; throughput is 1 access per cycle.
- starve_cnt:
  - Increments when d_req=1 and D is not granted, saturating at MAX_WAIT.
  - Clears when D is granted or d_req=0.
- Transitions:
  - S_SHARE -> S_BURST when D is granted with d_lock=1; burst_cnt is set to 1.
  - While in S_BURST, each D grant increments burst_cnt.
  - S_BURST -> S_SHARE when d_lock=0, or when d_req=0, or when a D grant brings burst_cnt to BURST_MAX.
  - The cycle after leaving S_BURST, a pending c_req wins even if d_req and d_lock are still high; the CPU is never starved beyond BURST_MAX+1 cycles.
- Simultaneous events:
  - When c_req and d_req rise together with starve_cnt < MAX_WAIT, C wins.
  - d_lock with no d_req has no effect.
- Reset mid-operation:
  - Any in-flight rvalid is dropped and the state returns to S_SHARE.
  - Requesters must re-issue.
- MMIO addresses (1000–1004) pass through unchanged; the arbiter does not decode addresses.

Test Plan:
- Only c_req, read addr 5 with RAM[5]=0xA5 -> c_gnt same cycle, c_rvalid=1 next cycle, c_rdata=0xA5; d_gnt=0.
- c_req and d_req both held high continuously (d_lock=0), MAX_WAIT=4 -> grants C,C,C,C,D,C,C,C,C,D...; starve_cnt returns to 0 after each D grant.
- d_req+d_lock held, c_req high, BURST_MAX=8, starve forces first D grant -> 8 consecutive d_gnt with addrs streamed, d_rvalid trailing by 1, then 1 c_gnt, then burst resumes.
- CPU write addr 1001 data 0x1F while d_req high -> ram_wEn=1 only on the C-grant cycle, no c_rvalid; ram_wEn=0 on every D-grant cycle.
- Assert reset the cycle after a D read grant -> d_rvalid stays 0, state S_SHARE, all counters 0; after release, the first c_req is granted immediately.
- No requests for 10 cycles -> ram_wEn=0 throughout, no gnt/rvalid pulses.
